// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the 16-bit five-stage core: widths, ALU opcodes and
// the control bundle carried from ID into EX.
package id_ex_pipe_reg_pkg;

  localparam int DATA_W  = 16;
  localparam int RID_W   = 3;
  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'h2;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'h3;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'h4;
  localparam logic [ALUOP_W-1:0] ALU_NOT  = 4'h5;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'h6;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'h7;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'h8;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'h9;
  localparam logic [ALUOP_W-1:0] ALU_CMP  = 4'hA;
  localparam logic [ALUOP_W-1:0] ALU_PASS = 4'hB;

  // Any bundle with valid=0 and all side-effect bits clear is a harmless NOP.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic write_spec_reg;
    logic read_spec_reg;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{valid: 1'b0, reg_write: 1'b0, write_spec_reg: 1'b0,
                                 read_spec_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Saturating up-counter used for the pipeline debug statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Stops at all-ones so a long run never wraps back to a misleading small value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// MEM structural stall, plus saturating bubble/flush debug counters.
module id_ex_pipe_reg #(
  parameter int DATA_W  = id_ex_pipe_reg_pkg::DATA_W,
  parameter int RID_W   = id_ex_pipe_reg_pkg::RID_W,
  parameter int ALUOP_W = id_ex_pipe_reg_pkg::ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [RID_W-1:0]   id_rx,
  input  logic [RID_W-1:0]   id_ry,
  input  logic [RID_W-1:0]   id_rz,
  input  logic               id_uses_rx,
  input  logic               id_uses_ry,
  input  logic               id_reg_write,
  input  logic [RID_W-1:0]   id_wr_id,
  input  logic               id_write_spec_reg,
  input  logic               id_read_spec_reg,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]  id_op1,
  input  logic [DATA_W-1:0]  id_op2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic               flush,
  input  logic               mem_stall,
  output logic               ex_valid,
  output logic [RID_W-1:0]   ex_rx,
  output logic [RID_W-1:0]   ex_ry,
  output logic [RID_W-1:0]   ex_rz,
  output logic               ex_reg_write,
  output logic [RID_W-1:0]   ex_wr_id,
  output logic               ex_write_spec_reg,
  output logic               ex_read_spec_reg,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [DATA_W-1:0]  ex_op1,
  output logic [DATA_W-1:0]  ex_op2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [DATA_W-1:0]  ex_pc,
  output logic               hold_front,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  import id_ex_pipe_reg_pkg::*;

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  rx_hit;
  logic  ry_hit;
  logic  sp_hit;
  logic  lu;
  logic  load_nop;

  assign id_ctrl = '{valid: id_valid, reg_write: id_reg_write,
                     write_spec_reg: id_write_spec_reg, read_spec_reg: id_read_spec_reg,
                     mem_read: id_mem_read, mem_write: id_mem_write};

  assign ex_valid          = ex_ctrl.valid;
  assign ex_reg_write      = ex_ctrl.reg_write;
  assign ex_write_spec_reg = ex_ctrl.write_spec_reg;
  assign ex_read_spec_reg  = ex_ctrl.read_spec_reg;
  assign ex_mem_read       = ex_ctrl.mem_read;
  assign ex_mem_write      = ex_ctrl.mem_write;

  // A load in EX whose result the ID instruction needs cannot be forwarded in time.
  assign rx_hit = ex_ctrl.reg_write & id_uses_rx & (ex_wr_id == id_rx);
  assign ry_hit = ex_ctrl.reg_write & id_uses_ry & (ex_wr_id == id_ry);
  assign sp_hit = ex_ctrl.write_spec_reg & id_read_spec_reg;
  assign lu     = ex_ctrl.valid & ex_ctrl.mem_read & id_valid & (rx_hit | ry_hit | sp_hit);

  assign hold_front = ~flush & (mem_stall | lu);

  // Flush outranks the stall because the ID instruction is dead anyway.
  assign load_nop = flush | (~mem_stall & lu);

  always_ff @(posedge clk) begin
    if (rst || load_nop) begin
      ex_ctrl   <= CTRL_NOP;
      ex_rx     <= '0;
      ex_ry     <= '0;
      ex_rz     <= '0;
      ex_wr_id  <= '0;
      ex_alu_op <= '0;
      ex_op1    <= '0;
      ex_op2    <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
    end else if (!mem_stall) begin
      ex_ctrl   <= id_valid ? id_ctrl : CTRL_NOP;
      ex_rx     <= id_rx;
      ex_ry     <= id_ry;
      ex_rz     <= id_rz;
      ex_wr_id  <= id_wr_id;
      ex_alu_op <= id_alu_op;
      ex_op1    <= id_op1;
      ex_op2    <= id_op2;
      ex_imm    <= id_imm;
      ex_pc     <= id_pc;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lu & ~flush & ~mem_stall),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed, table-driven bench for id_ex_pipe_reg: reset, load-use bubbles,
// flush priority, MEM stall freezing and counter saturation.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [2:0]  rz;
    logic        urx;
    logic        ury;
    logic        rw;
    logic [2:0]  wr;
    logic        wsp;
    logic        rsp;
    logic        mr;
    logic        mw;
    logic [3:0]  alu;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] imm;
    logic [15:0] pc;
  } id_t;

  typedef struct {
    string name;
    id_t   id;
    logic  fl;
    logic  st;
    logic  exp_hold;
    id_t   exp_ex;
    int    exp_b;
    int    exp_f;
  } vec_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rx, id_uses_ry, id_reg_write;
  logic        id_write_spec_reg, id_read_spec_reg, id_mem_read, id_mem_write;
  logic [2:0]  id_rx, id_ry, id_rz, id_wr_id;
  logic [3:0]  id_alu_op;
  logic [15:0] id_op1, id_op2, id_imm, id_pc;
  logic        flush, mem_stall;
  logic        ex_valid, ex_reg_write, ex_write_spec_reg, ex_read_spec_reg;
  logic        ex_mem_read, ex_mem_write, hold_front;
  logic [2:0]  ex_rx, ex_ry, ex_rz, ex_wr_id;
  logic [3:0]  ex_alu_op;
  logic [15:0] ex_op1, ex_op2, ex_imm, ex_pc;
  logic [15:0] bubble_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rx(id_rx), .id_ry(id_ry), .id_rz(id_rz),
    .id_uses_rx(id_uses_rx), .id_uses_ry(id_uses_ry), .id_reg_write(id_reg_write),
    .id_wr_id(id_wr_id), .id_write_spec_reg(id_write_spec_reg),
    .id_read_spec_reg(id_read_spec_reg), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_op(id_alu_op), .id_op1(id_op1),
    .id_op2(id_op2), .id_imm(id_imm), .id_pc(id_pc),
    .flush(flush), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_rx(ex_rx), .ex_ry(ex_ry), .ex_rz(ex_rz),
    .ex_reg_write(ex_reg_write), .ex_wr_id(ex_wr_id),
    .ex_write_spec_reg(ex_write_spec_reg), .ex_read_spec_reg(ex_read_spec_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .hold_front(hold_front), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  function automatic id_t mk(input logic v, input logic [2:0] rx, input logic [2:0] ry,
                             input logic [2:0] rz, input logic urx, input logic ury,
                             input logic rw, input logic [2:0] wr, input logic wsp,
                             input logic rsp, input logic mr, input logic mw,
                             input logic [3:0] alu, input logic [15:0] op1,
                             input logic [15:0] op2, input logic [15:0] imm,
                             input logic [15:0] pc);
    id_t r;
    r = '{valid: v, rx: rx, ry: ry, rz: rz, urx: urx, ury: ury, rw: rw, wr: wr,
          wsp: wsp, rsp: rsp, mr: mr, mw: mw, alu: alu, op1: op1, op2: op2,
          imm: imm, pc: pc};
    return r;
  endfunction

  // An instruction that reaches EX with id_valid low keeps its data but loses its side effects.
  function automatic id_t kill(input id_t i);
    id_t r;
    r = i;
    r.valid = 1'b0; r.rw = 1'b0; r.wsp = 1'b0; r.rsp = 1'b0; r.mr = 1'b0; r.mw = 1'b0;
    return r;
  endfunction

  function automatic logic [85:0] ex_of(input id_t i);
    return {i.valid, i.rx, i.ry, i.rz, i.rw, i.wr, i.wsp, i.rsp, i.mr, i.mw,
            i.alu, i.op1, i.op2, i.imm, i.pc};
  endfunction

  function automatic logic [85:0] ex_actual();
    return {ex_valid, ex_rx, ex_ry, ex_rz, ex_reg_write, ex_wr_id, ex_write_spec_reg,
            ex_read_spec_reg, ex_mem_read, ex_mem_write, ex_alu_op, ex_op1, ex_op2,
            ex_imm, ex_pc};
  endfunction

  function automatic id_t rnd_id();
    logic [95:0] x;
    x = {$urandom, $urandom, $urandom};
    return id_t'(x[$bits(id_t)-1:0]);
  endfunction

  task automatic applyStimulus(input id_t i, input logic fl, input logic st);
    id_valid = i.valid; id_rx = i.rx; id_ry = i.ry; id_rz = i.rz;
    id_uses_rx = i.urx; id_uses_ry = i.ury; id_reg_write = i.rw; id_wr_id = i.wr;
    id_write_spec_reg = i.wsp; id_read_spec_reg = i.rsp; id_mem_read = i.mr;
    id_mem_write = i.mw; id_alu_op = i.alu; id_op1 = i.op1; id_op2 = i.op2;
    id_imm = i.imm; id_pc = i.pc;
    flush = fl; mem_stall = st;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check hold_front before the edge, state after it.
  task automatic step(input string name, input id_t i, input logic fl, input logic st,
                      input logic exp_hold, input id_t exp_ex, input int exp_b,
                      input int exp_f);
    @(negedge clk);
    applyStimulus(i, fl, st);
    #1;
    checkOutput({name, ".hold_front"}, 128'(hold_front), 128'(exp_hold));
    @(posedge clk);
    #1;
    checkOutput({name, ".ex"}, 128'(ex_actual()), 128'(ex_of(exp_ex)));
    checkOutput({name, ".bubble_cnt"}, 128'(bubble_cnt), 128'(exp_b));
    checkOutput({name, ".flush_cnt"}, 128'(flush_cnt), 128'(exp_f));
  endtask

  task automatic reset_check(input string name);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(rnd_id(), 1'($urandom), 1'($urandom));
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checkOutput({name, ".ex"}, 128'(ex_actual()), 128'(0));
      checkOutput({name, ".bubble_cnt"}, 128'(bubble_cnt), 128'(0));
      checkOutput({name, ".flush_cnt"}, 128'(flush_cnt), 128'(0));
      @(negedge clk);
      applyStimulus(rnd_id(), 1'($urandom), 1'($urandom));
    end
  endtask

  id_t  nop, lw_r3, add_r3, add_nouse, addi_r3, add_ry3, lw_sp, mfsp;
  vec_t vecs[$];

  initial begin
    nop       = '0;
    //             v  rx ry rz urx ury rw wr wsp rsp mr mw alu     op1      op2      imm      pc
    lw_r3     = mk(1, 1, 0, 0, 1,  0,  1, 3, 0,  0,  1, 0, OP_ADD, 16'h1000, 16'h0000, 16'h0004, 16'h0010);
    add_r3    = mk(1, 3, 2, 5, 1,  1,  1, 5, 0,  0,  0, 0, OP_ADD, 16'h0007, 16'h0009, 16'h0000, 16'h0012);
    add_nouse = mk(1, 3, 2, 6, 0,  1,  1, 6, 0,  0,  0, 0, OP_SUB, 16'h00A0, 16'h0B00, 16'h0011, 16'h0014);
    addi_r3   = mk(1, 3, 0, 0, 1,  0,  1, 3, 0,  0,  0, 0, OP_ADD, 16'h1234, 16'h0000, 16'hFFFB, 16'h0020);
    add_ry3   = mk(1, 1, 3, 7, 1,  1,  1, 7, 0,  0,  0, 0, OP_SUB, 16'h5555, 16'hAAAA, 16'h0000, 16'h0030);
    lw_sp     = mk(1, 2, 0, 0, 1,  0,  0, 0, 1,  0,  1, 0, OP_ADD, 16'h2000, 16'h0000, 16'h0002, 16'h0040);
    mfsp      = mk(1, 0, 0, 4, 0,  0,  1, 4, 0,  1,  0, 0, OP_ADD, 16'hBEEF, 16'h0000, 16'h0000, 16'h0042);

    //                 name          id         fl st hold exp_ex           b  f
    vecs.push_back('{"pass_lw",     lw_r3,     0, 0, 0, lw_r3,           0, 0});
    vecs.push_back('{"lu_rx",       add_r3,    0, 0, 1, nop,             1, 0});
    vecs.push_back('{"after_bub",   add_r3,    0, 0, 0, add_r3,          1, 0});
    vecs.push_back('{"lw2",         lw_r3,     0, 0, 0, lw_r3,           1, 0});
    vecs.push_back('{"no_use_rx",   add_nouse, 0, 0, 0, add_nouse,       1, 0});
    vecs.push_back('{"alu_wr3",     addi_r3,   0, 0, 0, addi_r3,         1, 0});
    vecs.push_back('{"alu_fwd",     add_r3,    0, 0, 0, add_r3,          1, 0});
    vecs.push_back('{"lw3",         lw_r3,     0, 0, 0, lw_r3,           1, 0});
    vecs.push_back('{"lu_ry",       add_ry3,   0, 0, 1, nop,             2, 0});
    vecs.push_back('{"ry_pass",     add_ry3,   0, 0, 0, add_ry3,         2, 0});
    vecs.push_back('{"lw_sp",       lw_sp,     0, 0, 0, lw_sp,           2, 0});
    vecs.push_back('{"lu_sp",       mfsp,      0, 0, 1, nop,             3, 0});
    vecs.push_back('{"sp_pass",     mfsp,      0, 0, 0, mfsp,            3, 0});
    vecs.push_back('{"lw4",         lw_r3,     0, 0, 0, lw_r3,           3, 0});
    vecs.push_back('{"flush_all",   add_r3,    1, 1, 0, nop,             3, 1});
    vecs.push_back('{"lw5",         lw_r3,     0, 0, 0, lw_r3,           3, 1});
    vecs.push_back('{"id_invalid",  kill(add_r3), 0, 0, 0, kill(add_r3), 3, 1});
    vecs.push_back('{"stall_hold",  lw_r3,     0, 1, 1, kill(add_r3),    3, 1});
    vecs.push_back('{"flush_stall", lw_r3,     1, 0, 0, nop,             3, 2});
    vecs.push_back('{"lw6",         lw_r3,     0, 0, 0, lw_r3,           3, 2});
    vecs.push_back('{"flush_lu",    add_r3,    1, 0, 0, nop,             3, 3});

    applyStimulus(nop, 1'b0, 1'b0);
    rst = 1'b1;
    reset_check("reset1");
    rst = 1'b0;

    foreach (vecs[k])
      step(vecs[k].name, vecs[k].id, vecs[k].fl, vecs[k].st, vecs[k].exp_hold,
           vecs[k].exp_ex, vecs[k].exp_b, vecs[k].exp_f);

    // A pending load-use pair held by a 3-cycle MEM stall yields exactly one bubble.
    step("s_lw", lw_r3, 0, 0, 0, lw_r3, 3, 3);
    for (int c = 0; c < 3; c++) step("s_freeze", add_r3, 0, 1, 1, lw_r3, 3, 3);
    step("s_bubble", add_r3, 0, 0, 1, nop, 4, 3);
    for (int c = 0; c < 2; c++) step("s_nop_held", add_r3, 0, 1, 1, nop, 4, 3);
    step("s_release", add_r3, 0, 0, 0, add_r3, 4, 3);

    reset_check("reset2");
    rst = 1'b0;
    applyStimulus(lw_r3, 1'b1, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("sat.flush_fffe", 128'(flush_cnt), 128'(16'hFFFE));
    @(posedge clk);
    #1;
    checkOutput("sat.flush_ffff", 128'(flush_cnt), 128'(16'hFFFF));
    repeat (4) @(posedge clk);
    #1;
    checkOutput("sat.flush_nowrap", 128'(flush_cnt), 128'(16'hFFFF));
    checkOutput("sat.bubble_idle", 128'(bubble_cnt), 128'(0));
    checkOutput("sat.ex_nop", 128'(ex_actual()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
